axi_rd_arbiter: RTL and testbench

- Shares the core's single AXI read channel (AR/R) between NREQ cache-side requesters, e.g. ICache and DCache/uncached.
- Each requester uses a simple req/resp burst interface. The block serialises them round-robin with one outstanding AXI read at a time.
- Sits between the requesters and the cpu-side AXI bus that feeds the clock-domain crossing.

---
 rtl/axi_rd_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// axi_rd_arbiter
//   Shares the core's single AXI read channel (AR/R) between NREQ cache-side
//   requesters. Requests are served round-robin with exactly one AXI read burst
//   in flight at a time. Read beats are forwarded combinationally to the
//   requester that owns the burst.
//
// Optional feature macro: LAIN_RD_ARB_PERF_EN
//   Defined  : per-requester 32-bit grant and wait-cycle counters are built.
//   Undefined: no counters; perf_grant_cnt / perf_wait_cnt are tied to 0.
//
// Ports
//   aclk, aresetn        clock, asynchronous active-low reset
//   req_valid/req_ready  per-requester request / one-cycle accept pulse
//   req_addr/len/size    packed per-requester burst descriptors
//   resp_valid           per-requester beat valid (granted requester only)
//   resp_data/last/err   broadcast beat data, last flag, error flag
//   ar_*                 AXI read address channel toward the bus
//   r_*                  AXI read data channel from the bus
//   perf_grant_cnt       packed per-requester grant counters
//   perf_wait_cnt        packed per-requester wait-cycle counters
// -----------------------------------------------------------------------------
module axi_rd_arbiter #(
  parameter int NREQ       = 2,
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*4-1:0]          req_len,
  input  logic [NREQ*3-1:0]          req_size,
  output logic [NREQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]      resp_data,
  output logic                       resp_last,
  output logic                       resp_err,
  output logic [ID_WIDTH-1:0]        ar_id,
  output logic [ADDR_WIDTH-1:0]      ar_addr,
  output logic [3:0]                 ar_len,
  output logic [2:0]                 ar_size,
  output logic [1:0]                 ar_burst,
  output logic                       ar_valid,
  input  logic                       ar_ready,
  input  logic [ID_WIDTH-1:0]        r_id,
  input  logic [DATA_WIDTH-1:0]      r_data,
  input  logic [1:0]                 r_resp,
  input  logic                       r_last,
  input  logic                       r_valid,
  output logic                       r_ready,
  output logic [NREQ*32-1:0]         perf_grant_cnt,
  output logic [NREQ*32-1:0]         perf_wait_cnt
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_AR   = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [1:0]            state_r;
  logic [IDX_W-1:0]      rr_ptr_r;
  logic [IDX_W-1:0]      grant_r;
  logic [ID_WIDTH-1:0]   ar_id_r;
  logic [ADDR_WIDTH-1:0] ar_addr_r;
  logic [3:0]            ar_len_r;
  logic [2:0]            ar_size_r;
  logic                  ar_valid_r;
  logic                  r_ready_r;

  logic                  win_found_s;
  logic [IDX_W-1:0]      win_idx_s;
  logic [IDX_W-1:0]      cand_s;
  logic                  hit_s;
  logic [ADDR_WIDTH-1:0] win_addr_s;
  logic [3:0]            win_len_s;
  logic [2:0]            win_size_s;
  logic                  in_idle_s;
  logic                  beat_s;
  logic                  id_mismatch_s;

  // Next requester index, wrapping at NREQ (NREQ need not be a power of two).
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] nxt;
    if (idx == IDX_W'(NREQ - 1)) begin
      nxt = '0;
    end else begin
      nxt = idx + IDX_W'(1);
    end
    return nxt;
  endfunction

  assign in_idle_s = (state_r == ST_IDLE);

  // Round-robin search: first pending requester at or after rr_ptr_r.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = rr_ptr_r;
    hit_s       = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      hit_s       = ~win_found_s & req_valid[cand_s];
      win_idx_s   = hit_s ? cand_s : win_idx_s;
      win_found_s = win_found_s | hit_s;
      cand_s      = wrap_inc(cand_s);
    end
  end

  // Select the winning requester's burst descriptor.
  always_comb begin
    win_addr_s = '0;
    win_len_s  = 4'd0;
    win_size_s = 3'd0;
    for (int i = 0; i < NREQ; i++) begin
      win_addr_s = (win_idx_s == IDX_W'(i)) ? req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] : win_addr_s;
      win_len_s  = (win_idx_s == IDX_W'(i)) ? req_len[i*4 +: 4] : win_len_s;
      win_size_s = (win_idx_s == IDX_W'(i)) ? req_size[i*3 +: 3] : win_size_s;
    end
  end

  // Accept pulse in IDLE and per-requester beat steering.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i]  = in_idle_s & win_found_s & (win_idx_s == IDX_W'(i));
      resp_valid[i] = beat_s & (grant_r == IDX_W'(i));
    end
  end

  // Transaction sequencing and capture of the AR fields at grant time.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r    <= ST_IDLE;
      rr_ptr_r   <= '0;
      grant_r    <= '0;
      ar_id_r    <= '0;
      ar_addr_r  <= '0;
      ar_len_r   <= 4'd0;
      ar_size_r  <= 3'd0;
      ar_valid_r <= 1'b0;
      r_ready_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (win_found_s) begin
            grant_r    <= win_idx_s;
            rr_ptr_r   <= wrap_inc(win_idx_s);
            ar_id_r    <= ID_WIDTH'(win_idx_s);
            ar_addr_r  <= win_addr_s;
            ar_len_r   <= win_len_s;
            ar_size_r  <= win_size_s;
            ar_valid_r <= 1'b1;
            state_r    <= ST_AR;
          end
        end
        ST_AR: begin
          // Fields stay frozen until the slave takes them.
          if (ar_ready) begin
            ar_valid_r <= 1'b0;
            r_ready_r  <= 1'b1;
            state_r    <= ST_DATA;
          end
        end
        ST_DATA: begin
          // Error beats do not abort; only the last beat ends the burst.
          if (r_valid && r_last) begin
            r_ready_r <= 1'b0;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          ar_valid_r <= 1'b0;
          r_ready_r  <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  // r_ready_r is high exactly while a burst's data phase is open.
  assign beat_s        = r_ready_r & r_valid;
  assign id_mismatch_s = (r_id != ar_id_r);

  assign resp_data = r_data;
  assign resp_last = beat_s & r_last;
  assign resp_err  = beat_s & ((r_resp != 2'b00) | id_mismatch_s);

  assign ar_id    = ar_id_r;
  assign ar_addr  = ar_addr_r;
  assign ar_len   = ar_len_r;
  assign ar_size  = ar_size_r;
  assign ar_burst = 2'b01;
  assign ar_valid = ar_valid_r;
  assign r_ready  = r_ready_r;

`ifdef LAIN_RD_ARB_PERF_EN
  logic [31:0] grant_cnt_r [NREQ];
  logic [31:0] wait_cnt_r  [NREQ];

  // Grant and wait-cycle counters; both wrap naturally at 2^32.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NREQ; i++) begin
        grant_cnt_r[i] <= 32'd0;
        wait_cnt_r[i]  <= 32'd0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          grant_cnt_r[i] <= grant_cnt_r[i] + 32'd1;
        end
        if (req_valid[i] && !req_ready[i]) begin
          wait_cnt_r[i] <= wait_cnt_r[i] + 32'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_perf
    assign perf_grant_cnt[g*32 +: 32] = grant_cnt_r[g];
    assign perf_wait_cnt[g*32 +: 32]  = wait_cnt_r[g];
  end
`else
  assign perf_grant_cnt = '0;
  assign perf_wait_cnt  = '0;
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_rd_arbiter
//   Self-checking bench for axi_rd_arbiter. The bench plays the requesters and
//   the AXI slave. Expected grants come from a round-robin pick over the pending
//   set; expected beats come from the data the bench itself returns. Perf
//   counters are compared against counts kept by the bench.
// -----------------------------------------------------------------------------
module tb_axi_rd_arbiter;

  localparam int NREQ       = 2;
  localparam int ID_WIDTH   = 4;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  logic                       aclk;
  logic                       aresetn;
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ*ADDR_WIDTH-1:0] req_addr;
  logic [NREQ*4-1:0]          req_len;
  logic [NREQ*3-1:0]          req_size;
  logic [NREQ-1:0]            resp_valid;
  logic [DATA_WIDTH-1:0]      resp_data;
  logic                       resp_last;
  logic                       resp_err;
  logic [ID_WIDTH-1:0]        ar_id;
  logic [ADDR_WIDTH-1:0]      ar_addr;
  logic [3:0]                 ar_len;
  logic [2:0]                 ar_size;
  logic [1:0]                 ar_burst;
  logic                       ar_valid;
  logic                       ar_ready;
  logic [ID_WIDTH-1:0]        r_id;
  logic [DATA_WIDTH-1:0]      r_data;
  logic [1:0]                 r_resp;
  logic                       r_last;
  logic                       r_valid;
  logic                       r_ready;
  logic [NREQ*32-1:0]         perf_grant_cnt;
  logic [NREQ*32-1:0]         perf_wait_cnt;

  // Requester-side descriptors
  bit          q_valid [NREQ];
  logic [31:0] q_addr  [NREQ];
  logic [3:0]  q_len   [NREQ];
  logic [2:0]  q_size  [NREQ];

  // Reference model
  int              m_ptr;
  int unsigned     m_wait  [NREQ];
  int unsigned     m_grant [NREQ];
  logic [NREQ-1:0] m_ready;

  int n_err;
  int n_chk;

  for (genvar g = 0; g < NREQ; g++) begin : g_req
    assign req_valid[g]                          = q_valid[g];
    assign req_addr[g*ADDR_WIDTH +: ADDR_WIDTH]  = q_addr[g];
    assign req_len[g*4 +: 4]                     = q_len[g];
    assign req_size[g*3 +: 3]                    = q_size[g];
  end

  axi_rd_arbiter #(
    .NREQ(NREQ), .ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len), .req_size(req_size),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_last(resp_last), .resp_err(resp_err),
    .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_valid(r_valid),
    .r_ready(r_ready),
    .perf_grant_cnt(perf_grant_cnt), .perf_wait_cnt(perf_wait_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached, summary so far errors=%0d of %0d", n_err, n_chk);
    $fatal(1, "bench timeout");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int w);
    logic [NREQ-1:0] v;
    v = (w < 0) ? '0 : (NREQ'(1) << w);
    return v;
  endfunction

  function automatic logic [NREQ-1:0] cur_valid();
    logic [NREQ-1:0] v;
    v = '0;
    for (int i = 0; i < NREQ; i++) v = v | (q_valid[i] ? onehot(i) : '0);
    return v;
  endfunction

  // Round-robin rule: first pending index searching upward from ptr, wrapping.
  function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
    logic [NREQ-1:0] t;
    for (int k = 0; k < NREQ; k++) begin
      t = v >> ((ptr + k) % NREQ);
      if (t[0]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // Advance one clock, updating the model's perf counts for the cycle just ended.
  task automatic tick();
    for (int i = 0; i < NREQ; i++) begin
      if (q_valid[i] && !m_ready[i]) m_wait[i]++;
      if (m_ready[i]) m_grant[i]++;
    end
    m_ready = '0;
    @(posedge aclk);
    #1;
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      m_wait[i]  = 0;
      m_grant[i] = 0;
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [3:0] l, input logic [2:0] s);
    q_valid[i] = 1'b1;
    q_addr[i]  = a;
    q_len[i]   = l;
    q_size[i]  = s;
  endtask

  task automatic apply_reset();
    aresetn  = 1'b0;
    ar_ready = 1'b0;
    r_valid  = 1'b0;
    r_last   = 1'b0;
    r_resp   = 2'b00;
    r_id     = '0;
    r_data   = '0;
    for (int i = 0; i < NREQ; i++) q_valid[i] = 1'b0;
    @(posedge aclk);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    model_reset();
  endtask

  task automatic check_perf(input string tag);
    for (int i = 0; i < NREQ; i++) begin
`ifdef LAIN_RD_ARB_PERF_EN
      check_eq({tag, "_grant"}, 64'(perf_grant_cnt[i*32 +: 32]), 64'(m_grant[i]));
      check_eq({tag, "_wait"},  64'(perf_wait_cnt[i*32 +: 32]),  64'(m_wait[i]));
`else
      check_eq({tag, "_grant_off"}, 64'(perf_grant_cnt[i*32 +: 32]), 64'd0);
      check_eq({tag, "_wait_off"},  64'(perf_wait_cnt[i*32 +: 32]),  64'd0);
`endif
    end
  endtask

  // One complete burst for requester w.
  //   renew: 0 drop request after grant, 1 new random request, 2 keep same request
  //   err_beat / badid_beat: beat index carrying bad rresp / bad rid (-1 none)
  task automatic do_burst(input int w, input int stall, input int err_beat, input logic [1:0] err_resp,
                          input int badid_beat, input int renew, input int gap_max);
    logic [31:0] e_addr;
    logic [3:0]  e_len;
    logic [2:0]  e_size;
    logic [31:0] d;
    logic [1:0]  rs;
    logic [3:0]  rid;
    logic        e_err;
    int          nb;
    int          gap;
    e_addr = q_addr[w];
    e_len  = q_len[w];
    e_size = q_size[w];
    nb     = int'(e_len) + 1;

    // Grant cycle
    @(negedge aclk);
    check_eq("req_ready", 64'(req_ready), 64'(onehot(w)));
    check_eq("ar_valid_idle", 64'(ar_valid), 64'd0);
    m_ready = onehot(w);
    tick();
    m_ptr = (w + 1) % NREQ;
    if (renew == 0) begin
      q_valid[w] = 1'b0;
    end else if (renew == 1) begin
      set_req(w, $urandom & 32'hFFFF_FFFC, 4'($urandom_range(0, 7)), 3'($urandom_range(0, 2)));
    end

    // Address phase, optionally stalled
    ar_ready = 1'b0;
    for (int s = 0; s <= stall; s++) begin
      if (s == stall) ar_ready = 1'b1;
      @(negedge aclk);
      check_eq("ar_valid", 64'(ar_valid), 64'd1);
      check_eq("ar_addr", 64'(ar_addr), 64'(e_addr));
      check_eq("resp_valid_ar", 64'(resp_valid), 64'd0);
      if (s == 0) begin
        check_eq("ar_id", 64'(ar_id), 64'(w));
        check_eq("ar_len", 64'(ar_len), 64'(e_len));
        check_eq("ar_size", 64'(ar_size), 64'(e_size));
        check_eq("ar_burst", 64'(ar_burst), 64'd1);
        check_eq("r_ready_ar", 64'(r_ready), 64'd0);
      end
      tick();
    end
    ar_ready = 1'b0;

    // Data phase
    for (int b = 0; b < nb; b++) begin
      gap = $urandom_range(0, gap_max);
      for (int g = 0; g < gap; g++) begin
        r_valid = 1'b0;
        @(negedge aclk);
        check_eq("resp_valid_gap", 64'(resp_valid), 64'd0);
        check_eq("r_ready_gap", 64'(r_ready), 64'd1);
        tick();
      end
      d     = $urandom;
      rs    = (b == err_beat) ? err_resp : 2'b00;
      rid   = (b == badid_beat) ? 4'(w + 1) : 4'(w);
      e_err = (rs != 2'b00) || (rid != 4'(w));
      r_valid = 1'b1;
      r_data  = d;
      r_resp  = rs;
      r_id    = rid;
      r_last  = (b == nb - 1);
      @(negedge aclk);
      check_eq("resp_valid", 64'(resp_valid), 64'(onehot(w)));
      check_eq("resp_data", 64'(resp_data), 64'(d));
      check_eq("resp_last", 64'(resp_last), (b == nb - 1) ? 64'd1 : 64'd0);
      check_eq("resp_err", 64'(resp_err), 64'(e_err));
      tick();
    end
    r_valid = 1'b0;
    r_last  = 1'b0;
    r_resp  = 2'b00;
  endtask

  initial begin
    int w;
    n_err = 0;
    n_chk = 0;
    for (int i = 0; i < NREQ; i++) begin
      q_valid[i] = 1'b0;
      q_addr[i]  = 32'd0;
      q_len[i]   = 4'd0;
      q_size[i]  = 3'd0;
    end
    model_reset();

    // Reset state
    aresetn = 1'b0;
    ar_ready = 1'b0; r_valid = 1'b0; r_last = 1'b0; r_resp = 2'b00; r_id = '0; r_data = '0;
    @(posedge aclk);
    @(negedge aclk);
    check_eq("rst_ar_valid", 64'(ar_valid), 64'd0);
    check_eq("rst_r_ready", 64'(r_ready), 64'd0);
    check_eq("rst_ar_addr", 64'(ar_addr), 64'd0);
    check_eq("rst_ar_id", 64'(ar_id), 64'd0);
    check_eq("rst_ar_len", 64'(ar_len), 64'd0);
    check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
    check_eq("rst_req_ready", 64'(req_ready), 64'd0);
    check_perf("rst_perf");
    apply_reset();

    // Single request
    set_req(0, 32'h1C00_0000, 4'd3, 3'd2);
    do_burst(0, 0, -1, 2'b00, -1, 0, 0);
    @(negedge aclk);
    check_eq("single_idle_ar_valid", 64'(ar_valid), 64'd0);
    check_eq("single_idle_r_ready", 64'(r_ready), 64'd0);
    tick();

    // AR stall of 5 cycles
    set_req(1, 32'h0000_4000, 4'd1, 3'd2);
    w = pick(cur_valid(), m_ptr);
    do_burst(w, 5, -1, 2'b00, -1, 0, 0);

    // Error beats: bad rresp on beat 2, then bad rid while grant=0
    set_req(0, 32'h0000_8000, 4'd3, 3'd2);
    do_burst(0, 0, 1, 2'b10, -1, 0, 0);
    set_req(0, 32'h0000_9000, 4'd3, 3'd2);
    do_burst(0, 0, -1, 2'b00, 2, 0, 0);

    // Contention: both held continuously, len 0
    apply_reset();
    set_req(0, 32'h0000_1000, 4'd0, 3'd2);
    set_req(1, 32'h0000_2000, 4'd0, 3'd2);
    do_burst(0, 0, -1, 2'b00, -1, 2, 0);
    do_burst(1, 0, -1, 2'b00, -1, 2, 0);
    do_burst(0, 0, -1, 2'b00, -1, 2, 0);
    do_burst(1, 0, -1, 2'b00, -1, 2, 0);
    q_valid[0] = 1'b0;
    q_valid[1] = 1'b0;

    // Async reset in the middle of a data phase
    apply_reset();
    set_req(0, 32'h0000_A000, 4'd3, 3'd2);
    @(negedge aclk);
    check_eq("ar_rst_grant", 64'(req_ready), 64'(onehot(0)));
    m_ready = onehot(0);
    tick();
    q_valid[0] = 1'b0;
    ar_ready = 1'b1;
    tick();
    ar_ready = 1'b0;
    r_valid = 1'b1; r_data = 32'h1111_2222; r_resp = 2'b00; r_id = 4'd0; r_last = 1'b0;
    @(negedge aclk);
    check_eq("ar_rst_beat1", 64'(resp_valid), 64'(onehot(0)));
    tick();
    r_data = 32'h3333_4444;
    #2;
    aresetn = 1'b0;
    #1;
    check_eq("ar_rst_ar_valid", 64'(ar_valid), 64'd0);
    check_eq("ar_rst_r_ready", 64'(r_ready), 64'd0);
    check_eq("ar_rst_resp_valid", 64'(resp_valid), 64'd0);
    r_valid = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    model_reset();
    set_req(1, 32'h0000_B000, 4'd1, 3'd1);
    w = pick(cur_valid(), m_ptr);
    do_burst(w, 0, -1, 2'b00, -1, 0, 0);

    // Perf: req 1 waits 3 cycles behind a req 0 burst
    apply_reset();
    set_req(0, 32'h0000_C000, 4'd0, 3'd2);
    set_req(1, 32'h0000_D000, 4'd0, 3'd2);
    do_burst(0, 0, -1, 2'b00, -1, 0, 0);
    do_burst(1, 0, -1, 2'b00, -1, 0, 0);
`ifdef LAIN_RD_ARB_PERF_EN
    check_eq("perf_wait1", 64'(perf_wait_cnt[63:32]), 64'd3);
    check_eq("perf_grant0", 64'(perf_grant_cnt[31:0]), 64'd1);
    check_eq("perf_grant1", 64'(perf_grant_cnt[63:32]), 64'd1);
`endif
    check_perf("perf_dir");

    // Randomized traffic against the model
    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!q_valid[i] && ($urandom_range(0, 2) == 0)) begin
          set_req(i, $urandom & 32'hFFFF_FFFC, 4'($urandom_range(0, 7)), 3'($urandom_range(0, 2)));
        end
      end
      w = pick(cur_valid(), m_ptr);
      if (w < 0) begin
        @(negedge aclk);
        check_eq("rnd_idle_ready", 64'(req_ready), 64'd0);
        check_eq("rnd_idle_ar_valid", 64'(ar_valid), 64'd0);
        tick();
      end else begin
        do_burst(w, $urandom_range(0, 3),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1,
                 2'($urandom_range(1, 3)),
                 ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : -1,
                 int'($urandom_range(0, 1)), 2);
      end
    end
    check_perf("perf_rnd");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
